// File: rtl/fft_ctrl_pkg.sv
// Shared types for the FFT frame controller: FSM state encoding and counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_ctrl_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } ctrl_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_sample_bank.sv
// One N x WIDTH sample bank: indexed single-word write, full-width parallel read.
// Latency: a write is visible on dat the cycle after the write edge.
// Backpressure: none; every asserted write enable is taken.
module sample_bank #(
    parameter int WIDTH = 20,
    parameter int N     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(N)-1:0]       idx,
    input  logic [WIDTH-1:0]           wdat,
    output logic [N-1:0][WIDTH-1:0]    dat
);

    // Bank storage: cleared on reset, one word written per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat <= '0;
        end else if (we) begin
            dat[idx] <= wdat;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Double-buffered frame capture for fft_256: fills one bank, freezes the other, runs start/done handshake.
// Latency: fft_start the cycle after the N-th sample; frame_valid the cycle after fft_done.
// Backpressure: none on the sample stream; a frame filled while the FFT is busy is dropped and counted.
// Optional watchdog on the BUSY wait is built when FFT_CTRL_WATCHDOG_EN is defined.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int WIDTH       = 20,
    parameter int N           = 256,
    parameter int SAMPLE_W    = 12,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sample_valid,
    input  logic [SAMPLE_W-1:0]        sample_in,
    output logic                       fft_start,
    input  logic                       fft_done,
    output logic [N-1:0][WIDTH-1:0]    time_samples,
    output logic                       frame_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [CNT_W-1:0]           drop_count,
    output logic [CNT_W-1:0]           frame_count,
    output logic                       timeout_err
);

    localparam int IDX_W = $clog2(N);

    ctrl_state_t               state;
    ctrl_state_t               state_nxt;
    logic [IDX_W-1:0]          wr_idx;
    logic                      fill_sel;
    logic                      cap;
    logic                      full;
    logic                      done_ok;
    logic                      swap;
    logic                      drop;
    logic                      timeout;
    logic [WIDTH-1:0]          wr_dat;
    logic [N-1:0][WIDTH-1:0]   bank0_dat;
    logic [N-1:0][WIDTH-1:0]   bank1_dat;

    assign cap     = enable & sample_valid;
    assign full    = cap && (wr_idx == IDX_W'(N-1));
    // Only a done seen while BUSY completes a frame; stray dones elsewhere are ignored.
    assign done_ok = (state == BUSY) && fft_done;
    // A full bank is handed over when the FFT is idle or finishing in this very cycle.
    assign swap    = full && ((state == IDLE) || done_ok);
    // Any other full bank is discarded; wr_idx has already wrapped so the bank refills from 0.
    assign drop    = full && !swap;
    assign wr_dat  = WIDTH'(sample_in);

    sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank0 (
        .clk  (clk),
        .rst  (rst),
        .we   (cap & ~fill_sel),
        .idx  (wr_idx),
        .wdat (wr_dat),
        .dat  (bank0_dat)
    );

    sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank1 (
        .clk  (clk),
        .rst  (rst),
        .we   (cap & fill_sel),
        .idx  (wr_idx),
        .wdat (wr_dat),
        .dat  (bank1_dat)
    );

    // The FFT always sees the bank that is not being filled.
    assign time_samples = fill_sel ? bank0_dat : bank1_dat;

`ifdef FFT_CTRL_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_cnt;

    // Watchdog counts cycles spent in BUSY, restarting from 0 on each entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == BUSY) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout = (state == BUSY) && !fft_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (timeout) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign timeout_err        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: START lasts one cycle, BUSY waits for done (or the watchdog).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full) state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY: begin
                if (fft_done) begin
                    state_nxt = full ? START : IDLE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state only.
    always_comb begin
        fft_start = (state == START);
        busy      = (state == START) || (state == BUSY);
    end

    // Write pointer: advances per accepted sample, held at 0 while capture is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
        end else if (!enable) begin
            wr_idx <= '0;
        end else if (sample_valid) begin
            wr_idx <= wr_idx + 1'b1;
        end
    end

    // Bank select flips on every handover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_sel <= 1'b0;
        end else if (swap) begin
            fill_sel <= ~fill_sel;
        end
    end

    // Completion pulse, frame counter and drop accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
            drop_count  <= '0;
        end else begin
            frame_valid <= done_ok;
            frame_count <= frame_count + CNT_W'(done_ok);
            if (drop) begin
                overrun    <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a small fft_256 done-delay model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fft_frame_ctrl;

    localparam int WIDTH    = 20;
    localparam int N        = 256;
    localparam int SAMPLE_W = 12;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enable = 1'b0;
    logic                    sample_valid = 1'b0;
    logic [SAMPLE_W-1:0]     sample_in = '0;
    logic                    fft_done = 1'b0;
    logic                    fft_start;
    logic [N-1:0][WIDTH-1:0] time_samples;
    logic                    frame_valid;
    logic                    busy;
    logic                    overrun;
    logic [15:0]             drop_count;
    logic [15:0]             frame_count;
    logic                    timeout_err;

    fft_frame_ctrl #(
        .WIDTH(WIDTH), .N(N), .SAMPLE_W(SAMPLE_W), .TIMEOUT_CYC(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .time_samples (time_samples),
        .frame_valid  (frame_valid),
        .busy         (busy),
        .overrun      (overrun),
        .drop_count   (drop_count),
        .frame_count  (frame_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t start_q[$];
    exp_t fv_q[$];
    exp_t mon_e;
    int   mon_bad;
    int   errors = 0;
    int   checks = 0;
    int   last_edge = 0;
    int   done_delay = 20;
    bit   fft_auto = 1'b1;
    bit   stray_done = 1'b0;
    int   exp_frames = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One sample per call, accepted at the next rising edge; last_edge records that edge.
    task automatic send(input int v);
        sample_valid = 1'b1;
        sample_in    = SAMPLE_W'(v);
        @(posedge clk);
        #1;
        last_edge = cyc;
    endtask

    task automatic send_frame(input int base, input int n);
        for (int i = 0; i < n; i++) send(base + i);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_start(input int base);
        start_q.push_back('{cyc: last_edge, val: base});
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_frames = 0;
    endtask

    // FFT model: done pulses done_delay cycles after a start it sees; also pushes the completion it implies.
    initial begin
        forever begin
            @(negedge clk);
            fft_done = 1'b0;
            if (rst) begin
                model_cnt = 0;
            end else begin
                if (stray_done) begin
                    fft_done   = 1'b1;
                    stray_done = 1'b0;
                end
                if (model_cnt > 0) begin
                    model_cnt--;
                    if (model_cnt == 0) begin
                        fft_done = 1'b1;
                        exp_frames++;
                        fv_q.push_back('{cyc: cyc + 1, val: exp_frames});
                    end
                end
                if (fft_start && fft_auto) model_cnt = done_delay;
            end
        end
    end

    // Monitor: every start and frame_valid pulse must match the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fft_start) begin
                    if (start_q.size() == 0) begin
                        chk("start_unexpected", fft_start, 0);
                    end else begin
                        mon_e = start_q.pop_front();
                        chk("start_cycle", cyc, mon_e.cyc);
                        mon_bad = 0;
                        for (int i = 0; i < N; i++)
                            if (time_samples[i] !== WIDTH'((mon_e.val + i) % 4096)) mon_bad++;
                        chk("start_frame_bad_words", mon_bad, 0);
                    end
                end
                if (frame_valid) begin
                    if (fv_q.size() == 0) begin
                        chk("frame_valid_unexpected", frame_valid, 0);
                    end else begin
                        mon_e = fv_q.pop_front();
                        chk("frame_valid_cycle", cyc, mon_e.cyc);
                        chk("frame_count_at_valid", frame_count, mon_e.val);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_time_samples_any", |time_samples, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // Basic frame 0..255, done 20 cycles after start
        @(posedge clk);
        #1;
        enable = 1'b1;
        send_frame(0, N);
        push_start(0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_busy_after_start", busy, 1);
        chk("t1_start_one_cycle", fft_start, 0);
        idle(30);
        @(negedge clk);
        chk("t1_frame_count", frame_count, 1);
        chk("t1_overrun", overrun, 0);
        chk("t1_busy_done", busy, 0);

        // Slow FFT: second frame dropped, frozen data untouched, later frame starts normally
        done_delay = 600;
        send_frame(1000, N);
        push_start(1000);
        send_frame(2000, N);
        @(negedge clk);
        chk("t2_overrun", overrun, 1);
        chk("t2_drop_count", drop_count, 1);
        chk("t2_busy_still", busy, 1);
        chk("t2_frozen_word5", time_samples[5], 1005);
        idle(400);
        done_delay = 20;
        send_frame(3000, N);
        push_start(3000);
        idle(30);
        @(negedge clk);
        chk("t2_drop_count_final", drop_count, 1);
        chk("t2_frame_count", frame_count, 3);

        // done coincident with the last sample of the next frame
        do_reset();
        done_delay = 255;
        send_frame(500, N);
        push_start(500);
        send_frame(1500, N);
        push_start(1500);
        done_delay = 20;
        idle(30);
        @(negedge clk);
        chk("t3_drop_count", drop_count, 0);
        chk("t3_overrun", overrun, 0);
        chk("t3_frame_count", frame_count, 2);

        // enable dropped mid-frame: partial frame discarded, valid ignored while low
        send_frame(2500, 100);
        enable       = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 12'd7;
        repeat (5) @(posedge clk);
        #1;
        sample_valid = 1'b0;
        enable       = 1'b1;
        send_frame(3500, N);
        push_start(3500);
        idle(30);
        @(negedge clk);
        chk("t4_frame_count", frame_count, 3);

        // Reset while BUSY, then a stray done
        done_delay = 100;
        send_frame(200, N);
        push_start(200);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_fft_start", fft_start, 0);
        chk("t5_busy", busy, 0);
        chk("t5_frame_count", frame_count, 0);
        chk("t5_time_samples_any", |time_samples, 0);
        chk("t5_frame_valid", frame_valid, 0);
        exp_frames = 0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        stray_done = 1'b1;
        idle(10);
        @(negedge clk);
        chk("t5_stray_done_count", frame_count, 0);
        chk("t5_stray_done_busy", busy, 0);

`ifdef FFT_CTRL_WATCHDOG_EN
        // Watchdog: no done, timeout after 64 BUSY cycles, next frame normal
        fft_auto = 1'b0;
        send_frame(300, N);
        push_start(300);
        while (cyc < last_edge + 64) @(negedge clk);
        chk("t6_busy_before_timeout", busy, 1);
        chk("t6_no_timeout_yet", timeout_err, 0);
        @(negedge clk);
        chk("t6_idle_after_timeout", busy, 0);
        chk("t6_timeout_err", timeout_err, 1);
        fft_auto   = 1'b1;
        done_delay = 20;
        send_frame(600, N);
        push_start(600);
        idle(30);
        @(negedge clk);
        chk("t6_frame_count", frame_count, 1);
        chk("t6_timeout_sticky", timeout_err, 1);
`else
        chk("timeout_err_tied", timeout_err, 0);
`endif

        chk("start_q_leftover", start_q.size(), 0);
        chk("fv_q_leftover", fv_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
